// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Shares one single-ported instruction/data memory between the fetch stage
// (F) and the memory stage (M). A three-state FSM grants one port at a time,
// holds the memory bus for LATENCY cycles and then returns read data with a
// one-cycle done pulse on the granted port.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_done)
//   if_rdata/if_done    fetched instruction, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (held until d_done)
//   d_rdata/d_done      load data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory bus
//   mem_rdata           memory read data, valid in the last access cycle
//   stall               combinational pipeline freeze
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration with a last_grant bit
//                  undefined -> fixed priority, data port wins
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [2:0] LastCnt = 3'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic          memWe_q, memWe_d;
  logic [DW-1:0] ifRdata_q, ifRdata_d;
  logic [DW-1:0] dRdata_q, dRdata_d;
  logic          ifDone_q, ifDone_d;
  logic          dDone_q, dDone_d;
  logic          ifElig, dElig, pickD;
`ifdef MEM_ARB_RR_EN
  // 1 = data port was granted last, 0 = fetch port
  logic          lastGrant_q, lastGrant_d;
`endif

  // A port whose done is high this cycle is not eligible, so a request that
  // is still held during its completion cycle is not granted twice.
  assign ifElig = if_req & ~ifDone_q;
  assign dElig  = d_req & ~dDone_q;

  // Arbitration choice, only meaningful in IDLE. Round robin hands a conflict
  // to the port that did not win last time; fixed priority favours data,
  // which belongs to the older instruction in the pipeline.
`ifdef MEM_ARB_RR_EN
  assign pickD = dElig & ~(ifElig & lastGrant_q);
`else
  assign pickD = dElig;
`endif

  // Next-state logic: grant in IDLE, count wait cycles while busy, and on the
  // last access cycle capture read data and raise the granted port's done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = memWe_q;
    ifRdata_d  = ifRdata_q;
    dRdata_d   = dRdata_q;
    ifDone_d   = 1'b0;
    dDone_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    lastGrant_d = lastGrant_q;
`endif
    case (state_q)
      IDLE: begin
        if (pickD) begin
          state_d    = BUSY_D;
          cnt_d      = 3'd0;
          memAddr_d  = d_addr;
          memWdata_d = d_wdata;
          memWe_d    = d_we;
`ifdef MEM_ARB_RR_EN
          lastGrant_d = 1'b1;
`endif
        end else if (ifElig) begin
          state_d   = BUSY_I;
          cnt_d     = 3'd0;
          memAddr_d = if_addr;
          memWe_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
          lastGrant_d = 1'b0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == LastCnt) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
          memWe_d = 1'b0;
          if (state_q == BUSY_I) begin
            ifRdata_d = mem_rdata;
            ifDone_d  = 1'b1;
          end else begin
            if (!memWe_q) begin
              dRdata_d = mem_rdata;
            end
            dDone_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
        memWe_d = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any in-flight access without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWe_q    <= 1'b0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
      ifDone_q   <= 1'b0;
      dDone_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      lastGrant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
      ifDone_q   <= ifDone_d;
      dDone_q    <= dDone_d;
`ifdef MEM_ARB_RR_EN
      lastGrant_q <= lastGrant_d;
`endif
    end
  end

  assign mem_en    = (state_q != IDLE);
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign if_rdata  = ifRdata_q;
  assign d_rdata   = dRdata_q;
  assign if_done   = ifDone_q;
  assign d_done    = dDone_q;
  assign stall     = (if_req & ~ifDone_q) | (d_req & ~dDone_q);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter. Instance dut runs with LATENCY=2,
// instance dut1 with LATENCY=1 for the back-to-back fetch case. Read data
// expected on each done pulse is queued when the request is driven and
// popped by a monitor when the done pulse appears.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata, memRdata;
  logic        ifDone, dDone, memEn, memWe, stall;

  logic        ifReq1;
  logic [31:0] ifAddr1, ifRdata1, dRdata1, memAddr1, memWdata1, memRdata1;
  logic        ifDone1, dDone1, memEn1, memWe1, stall1;

  int testsRun;
  int testsFailed;
  logic [31:0] ifQ[$];
  logic [31:0] dQ[$];
  logic [31:0] dRdataModel;

  // Simple memory contents: two fixed words, everything else address-derived.
  function automatic logic [31:0] modelData(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0093;
    if (a == 32'h1001_0008) return 32'h1234_5678;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  assign memRdata  = modelData(memAddr);
  assign memRdata1 = modelData(memAddr1);

  mem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_done(ifDone),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_rdata(dRdata), .d_done(dDone),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .stall(stall)
  );

  mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(ifReq1), .if_addr(ifAddr1), .if_rdata(ifRdata1), .if_done(ifDone1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(dRdata1), .d_done(dDone1),
    .mem_en(memEn1), .mem_we(memWe1), .mem_addr(memAddr1), .mem_wdata(memWdata1),
    .mem_rdata(memRdata1), .stall(stall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Start of a cycle: just after the rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Middle of a cycle: falling edge, where outputs are sampled.
  task automatic mid();
    @(negedge clk);
  endtask

  // Raise a request on one port and queue the read data its done should show.
  task automatic applyStimulus(input bit isData, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (isData) begin
      dReq   = 1'b1;
      dWe    = we;
      dAddr  = addr;
      dWdata = wdata;
      if (!we) dRdataModel = modelData(addr);
      dQ.push_back(dRdataModel);
    end else begin
      ifReq  = 1'b1;
      ifAddr = addr;
      ifQ.push_back(modelData(addr));
    end
  endtask

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (ifDone) begin
      if (ifQ.size() == 0) checkOutput("ifDoneUnexpected", 32'd1, 32'd0);
      else checkOutput("ifRdata", ifRdata, ifQ.pop_front());
    end
    if (dDone) begin
      if (dQ.size() == 0) checkOutput("dDoneUnexpected", 32'd1, 32'd0);
      else checkOutput("dRdata", dRdata, dQ.pop_front());
      checkOutput("doneExclusive", {31'd0, ifDone}, 32'd0);
    end
  end

  initial begin
    bit expD;
    bit pendI, pendD;
    bit prevEn;
    int nI, nD, doneI, doneD, grants;
    logic [7:0] en1Exp, done1Exp;

    testsRun = 0;
    testsFailed = 0;
    dRdataModel = 32'h0;
    rst = 1'b0;
    ifReq = 1'b0; ifAddr = 32'h0;
    dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWdata = 32'h0;
    ifReq1 = 1'b0; ifAddr1 = 32'h0;

    // Reset values
    cyc(); cyc(); mid();
    checkOutput("rstMemEn", {31'd0, memEn}, 32'd0);
    checkOutput("rstMemWe", {31'd0, memWe}, 32'd0);
    checkOutput("rstDone", {30'd0, ifDone, dDone}, 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'd0);
    checkOutput("rstMemWdata", memWdata, 32'd0);
    checkOutput("rstRdata", ifRdata | dRdata, 32'd0);
    checkOutput("rstStall", {31'd0, stall}, 32'd0);
    cyc(); rst = 1'b1;

    // Reset during the first busy cycle abandons the fetch
    cyc(); ifReq = 1'b1; ifAddr = 32'h0040_0040;
    cyc();
    checkOutput("midBusyEn", {31'd0, memEn}, 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("midRstEn", {31'd0, memEn}, 32'd0);
    checkOutput("midRstDone", {31'd0, ifDone}, 32'd0);
    ifReq = 1'b0;
    cyc(); rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(); mid();
      checkOutput("postRstIdle", {30'd0, memEn, ifDone}, 32'd0);
    end

    // Single fetch, LATENCY=2
    cyc(); applyStimulus(1'b0, 1'b0, 32'h0040_0000, 32'h0);
    mid();
    checkOutput("sfStall0", {31'd0, stall}, 32'd1);
    checkOutput("sfEn0", {31'd0, memEn}, 32'd0);
    for (int c = 1; c <= 2; c++) begin
      cyc(); mid();
      checkOutput("sfEn", {31'd0, memEn}, 32'd1);
      checkOutput("sfAddr", memAddr, 32'h0040_0000);
      checkOutput("sfWe", {31'd0, memWe}, 32'd0);
      checkOutput("sfStall", {31'd0, stall}, 32'd1);
    end
    cyc(); mid();
    checkOutput("sfDone", {31'd0, ifDone}, 32'd1);
    checkOutput("sfStall3", {31'd0, stall}, 32'd0);
    checkOutput("sfEn3", {31'd0, memEn}, 32'd0);
    cyc(); ifReq = 1'b0; mid();
    checkOutput("sfDonePulse", {31'd0, ifDone}, 32'd0);
    checkOutput("sfHold", ifRdata, 32'h0050_0093);

    // Simultaneous requests: data first (also under round robin, since the
    // previous grant went to fetch)
    cyc();
    applyStimulus(1'b1, 1'b0, 32'h1001_0004, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0040_0004, 32'h0);
    mid();
    checkOutput("simStall0", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= 2; c++) begin
      cyc(); mid();
      checkOutput("simDAddr", memAddr, 32'h1001_0004);
      checkOutput("simDEn", {31'd0, memEn}, 32'd1);
    end
    cyc(); mid();
    checkOutput("simDDone", {30'd0, dDone, ifDone}, 32'd2);
    checkOutput("simStall3", {31'd0, stall}, 32'd1);
    cyc(); dReq = 1'b0;
    mid();
    checkOutput("simIAddr4", {memAddr[31:1], memEn}, {31'h0020_0002, 1'b1});
    cyc(); mid();
    checkOutput("simIAddr5", {memAddr[31:1], memEn}, {31'h0020_0002, 1'b1});
    cyc(); mid();
    checkOutput("simIDone", {30'd0, dDone, ifDone}, 32'd1);
    checkOutput("simStall6", {31'd0, stall}, 32'd0);
    cyc(); ifReq = 1'b0;

    // Load a known word, then a store that must not disturb d_rdata
    cyc(); applyStimulus(1'b1, 1'b0, 32'h1001_0008, 32'h0);
    cyc(); cyc(); cyc(); mid();
    checkOutput("ldDone", {31'd0, dDone}, 32'd1);
    cyc(); dReq = 1'b0;
    cyc(); applyStimulus(1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF);
    for (int c = 1; c <= 2; c++) begin
      cyc(); mid();
      checkOutput("stWe", {31'd0, memWe}, 32'd1);
      checkOutput("stWdata", memWdata, 32'hDEAD_BEEF);
      checkOutput("stAddr", memAddr, 32'h1001_0000);
    end
    cyc(); mid();
    checkOutput("stDone", {31'd0, dDone}, 32'd1);
    checkOutput("stWeOff", {31'd0, memWe}, 32'd0);
    cyc(); dReq = 1'b0; mid();
    checkOutput("stDonePulse", {31'd0, dDone}, 32'd0);
    checkOutput("stRdataHeld", dRdata, 32'h1234_5678);

    // Both ports re-request right after each done, three transfers each
`ifdef MEM_ARB_RR_EN
    expD = 1'b0;
`else
    expD = 1'b1;
`endif
    cyc();
    applyStimulus(1'b0, 1'b0, 32'h0040_0100, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h1001_0100, 32'h0);
    nI = 1; nD = 1; doneI = 0; doneD = 0; grants = 0;
    pendI = 1'b0; pendD = 1'b0; prevEn = 1'b0;
    for (int c = 0; c < 80 && (doneI < 3 || doneD < 3); c++) begin
      if (c > 0) begin
        cyc();
        if (pendI) begin
          pendI = 1'b0;
          if (nI < 3) begin
            applyStimulus(1'b0, 1'b0, 32'h0040_0100 + 32'(4 * nI), 32'h0);
            nI++;
          end else ifReq = 1'b0;
        end
        if (pendD) begin
          pendD = 1'b0;
          if (nD < 3) begin
            applyStimulus(1'b1, 1'b0, 32'h1001_0100 + 32'(4 * nD), 32'h0);
            nD++;
          end else dReq = 1'b0;
        end
      end
      mid();
      if (memEn && !prevEn) begin
        checkOutput("rrGrantPort", {31'd0, memAddr[28]}, {31'd0, expD});
        expD = ~expD;
        grants++;
      end
      prevEn = memEn;
      if (ifDone) begin doneI++; pendI = 1'b1; end
      if (dDone) begin doneD++; pendD = 1'b1; end
    end
    checkOutput("rrGrants", 32'(grants), 32'd6);
    cyc(); ifReq = 1'b0; dReq = 1'b0;
    cyc();

    // Back-to-back fetches on the LATENCY=1 instance
    en1Exp   = 8'b0001_0010;
    done1Exp = 8'b0010_0100;
    cyc(); ifReq1 = 1'b1; ifAddr1 = 32'h0040_0200;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      if (c == 3) ifAddr1 = 32'h0040_0204;
      if (c == 6) ifReq1 = 1'b0;
      mid();
      checkOutput("b2bEn", {31'd0, memEn1}, {31'd0, en1Exp[c]});
      checkOutput("b2bDone", {31'd0, ifDone1}, {31'd0, done1Exp[c]});
      if (c == 2) checkOutput("b2bData0", ifRdata1, modelData(32'h0040_0200));
      if (c == 4) checkOutput("b2bAddr1", memAddr1, 32'h0040_0204);
      if (c == 5) checkOutput("b2bData1", ifRdata1, modelData(32'h0040_0204));
    end

    checkOutput("ifQEmpty", 32'(ifQ.size()), 32'd0);
    checkOutput("dQEmpty", 32'(dQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
